dcache_wt: RTL

- Direct-mapped, write-through, no-write-allocate data cache.
- Sits in the MEM stage between the pipeline's load/store controls and a multi-cycle backing data memory.
- Read hits return data in the same cycle. Misses and all stores stall the pipeline through stall_o until the backing memory completes a req/ack handshake.
- Provides hit/miss counters for performance bring-up.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/dcache_array.sv | 46 ++++
 rtl/dcache_wt.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Definitions shared by the data cache and the backing data memory:
// cache FSM state encoding, the word width and word-address indexing.
package cpu_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        DC_IDLE,
        DC_RD_REQ,
        DC_WR_REQ,
        DC_RESP
    } dc_state_e;

    // Word number of a byte address. The backing memory indexes with the same function.
    function automatic logic [29:0] word_index(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Storage for the direct-mapped cache: valid, tag and data word per line.
// Only the valid bits are reset; one combinational read port, one write port.
module dcache_array
    import cpu_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [WORD_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [WORD_W-1:0] wr_data
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [WORD_W-1:0] data_q [LINES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data are meaningless until their valid bit is set, so no reset here.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Load hits answer in the same cycle; misses and stores stall until the memory acks.
module dcache_wt
    import cpu_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [31:0]       addr_i,
    input  logic [WORD_W-1:0] data_i,
    output logic [WORD_W-1:0] data_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [WORD_W-1:0] mem_rdata_i,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    dc_state_e         state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic              resp_load_q;
    logic [WORD_W-1:0] resp_data_q;
    logic [31:0]       hit_cnt_q;
    logic [31:0]       miss_cnt_q;

    logic [29:0]       word;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              line_valid;
    logic [TAG_W-1:0]  line_tag;
    logic [WORD_W-1:0] line_data;
    logic              hit;
    logic              is_store;
    logic              is_load;
    logic              arr_we;
    logic [WORD_W-1:0] arr_wdata;

    assign word     = word_index(addr_i);
    assign idx      = word[IDX_W-1:0];
    assign tag      = word[29:IDX_W];
    assign hit      = line_valid && (line_tag == tag);
    // A simultaneous read and write request is handled as a store.
    assign is_store = MemWrite_i;
    assign is_load  = MemRead_i && !MemWrite_i;

    // Refills always allocate; stores only update a line that already holds the address.
    assign arr_we    = mem_ack_i && ((state_q == DC_RD_REQ) || (state_q == DC_WR_REQ && hit));
    assign arr_wdata = (state_q == DC_RD_REQ) ? mem_rdata_i : data_i;

    dcache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rd_idx   (idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (arr_we),
        .wr_idx   (idx),
        .wr_tag   (tag),
        .wr_data  (arr_wdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= DC_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            resp_load_q <= 1'b0;
            resp_data_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            case (state_q)
                DC_IDLE: begin
                    if (is_store) begin
                        state_q   <= DC_WR_REQ;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b1;
                    end else if (is_load) begin
                        if (hit) begin
                            if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
                        end else begin
                            if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
                            state_q   <= DC_RD_REQ;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= 1'b0;
                        end
                    end
                end
                DC_RD_REQ: begin
                    if (mem_ack_i) begin
                        state_q     <= DC_RESP;
                        mem_req_q   <= 1'b0;
                        resp_load_q <= 1'b1;
                        resp_data_q <= mem_rdata_i;
                    end
                end
                DC_WR_REQ: begin
                    if (mem_ack_i) begin
                        state_q     <= DC_RESP;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        resp_load_q <= 1'b0;
                    end
                end
                DC_RESP: begin
                    state_q <= DC_IDLE;
                end
                default: begin
                    state_q   <= DC_IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    // Outputs are forced quiet while reset is held so a mid-transaction reset frees the pipeline at once.
    always_comb begin
        stall_o = 1'b0;
        data_o  = '0;
        if (!rst_i) begin
            case (state_q)
                DC_IDLE: begin
                    if (is_store || (is_load && !hit)) stall_o = 1'b1;
                    if (is_load && hit) data_o = line_data;
                end
                DC_RD_REQ, DC_WR_REQ: stall_o = 1'b1;
                DC_RESP: begin
                    if (resp_load_q) data_o = resp_data_q;
                end
                default: stall_o = 1'b0;
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = {addr_i[31:2], 2'b00};
    assign mem_wdata_o = data_i;
    assign hit_cnt_o   = hit_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;

endmodule
